// File: rtl/top_fir_filter.sv
// Self-contained 5-tap direct-form FIR: an input sample ROM streamed one word per
// clock into a 7-cycle pipelined filter whose result is probed at Direct_filter.direct_out.

module fir_input_rom #(
  parameter int IN_W  = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AW-1:0]          addr,
  output logic signed [IN_W-1:0] data
);

  // Contents are preloaded from outside; there is no write port.
  logic [IN_W-1:0] array [DEPTH];

  // NOTE: only the read register is reset; the storage array has no reset so it can map onto ROM/RAM macros.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) data <= '0;
    else       data <= array[addr];
  end

endmodule

module fir_direct_filter #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 22,
  parameter int TAPS   = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic signed [IN_W-1:0] x,
  output logic [OUT_W-1:0]       direct_out
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF [TAPS] =
    '{12'sh25d, 12'shc9d, 12'sh41d, 12'shca0, 12'sh652};

  logic signed [IN_W-1:0]   taps  [TAPS];
  logic signed [PROD_W-1:0] prod  [TAPS];
  logic signed [OUT_W-1:0]  sum_a [3];
  logic signed [OUT_W-1:0]  sum_b [2];
  logic signed [OUT_W-1:0]  sum_c;

  // NOTE: every register here uses non-blocking assignment so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) begin
        taps[i] <= '0;
        prod[i] <= '0;
      end
      for (int i = 0; i < 3; i++) sum_a[i] <= '0;
      for (int i = 0; i < 2; i++) sum_b[i] <= '0;
      sum_c      <= '0;
      direct_out <= '0;
    end else begin
      taps[0] <= x;
      for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
      // Operands widened to the product width first so the multiply is exact and signed.
      for (int i = 0; i < TAPS; i++) prod[i] <= PROD_W'(taps[i]) * PROD_W'(COEF[i]);
      sum_a[0]   <= OUT_W'(prod[0]) + OUT_W'(prod[1]);
      sum_a[1]   <= OUT_W'(prod[2]) + OUT_W'(prod[3]);
      sum_a[2]   <= OUT_W'(prod[4]);
      sum_b[0]   <= sum_a[0] + sum_a[1];
      sum_b[1]   <= sum_a[2];
      sum_c      <= sum_b[0] + sum_b[1];
      direct_out <= sum_c;
    end
  end

endmodule

module top_fir_filter #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 22,
  parameter int DEPTH  = 256,
  parameter int TAPS   = 5
) (
  input logic clk,
  input logic rstn
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]          addr;
  logic signed [IN_W-1:0] sample;
  logic [OUT_W-1:0]       filter_out;

  // Free-running address; wraps without clearing filter history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) addr <= '0;
    else       addr <= addr + 1'b1;
  end

  fir_input_rom #(.IN_W(IN_W), .DEPTH(DEPTH), .AW(AW)) DIRECT_INPUT_MEM (
    .clk  (clk),
    .rstn (rstn),
    .addr (addr),
    .data (sample)
  );

  fir_direct_filter #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .TAPS(TAPS)) Direct_filter (
    .clk        (clk),
    .rstn       (rstn),
    .x          (sample),
    .direct_out (filter_out)
  );

endmodule

// File: tb/tb_top_fir_filter.sv
// Directed bench for top_fir_filter: loads the ROM hierarchically, models y[n] in integer
// arithmetic and compares Direct_filter.direct_out each cycle through a latency queue.

module tb_top_fir_filter;

  logic clk;
  logic rstn;

  top_fir_filter dut (
    .clk  (clk),
    .rstn (rstn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int COEF_I [5] = '{605, -867, 1053, -864, 1618};

  logic signed [7:0] img [256];
  logic [21:0]       sb_q [$];
  int                n;
  int                checks;
  int                errors;

  function automatic logic [21:0] model_y(int idx);
    int acc;
    acc = 0;
    for (int i = 0; i < 5; i++)
      if (idx - i >= 0) acc += COEF_I[i] * int'(img[(idx - i) % 256]);
    return acc[21:0];
  endfunction

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic load_image(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       img[i] = (i == 0) ? 8'sh01 : 8'sh00;
        1:       img[i] = 8'sh01;
        2:       img[i] = (i == 0) ? 8'sh80 : 8'sh00;
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
      dut.DIRECT_INPUT_MEM.array[i] = img[i];
    end
  endtask

  // Called at a falling edge; the next rising edge becomes E1.
  task automatic release_reset();
    sb_q.delete();
    repeat (6) sb_q.push_back(22'h0);
    n = 0;
    rstn = 1'b1;
  endtask

  // Called at a falling edge; asserts reset between edges and checks it acts at once.
  task automatic assert_reset(input string tag, input int hold);
    #2 rstn = 1'b0;
    #1 check({tag, "_async"}, dut.Direct_filter.direct_out, 22'h0);
    @(negedge clk);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, "_held"}, dut.Direct_filter.direct_out, 22'h0);
    end
  endtask

  task automatic run(input int ncyc, input string tag);
    for (int c = 0; c < ncyc; c++) begin
      sb_q.push_back(model_y(n));
      n++;
      @(posedge clk);
      @(negedge clk);
      check(tag, dut.Direct_filter.direct_out, sb_q.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n      = 0;
    rstn   = 1'b0;

    load_image(0);
    #1 check("por_async", dut.Direct_filter.direct_out, 22'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("por_held", dut.Direct_filter.direct_out, 22'h0);
    end

    release_reset();
    run(20, "impulse");

    assert_reset("rst_step", 2);
    load_image(1);
    release_reset();
    run(270, "step");

    assert_reset("rst_neg", 2);
    load_image(2);
    release_reset();
    run(16, "neg_fs");

    assert_reset("rst_rand", 2);
    load_image(3);
    release_reset();
    run(50, "rand_pre");
    assert_reset("mid_stream", 3);
    release_reset();
    run(300, "golden");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
